// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and helpers for the instruction-cache refill sequencer.
package icache_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        WRITE = 2'd3
    } refill_state_t;

    // Width of one IRAM beat.
    localparam int BEAT_BITS = 32;

    // Mask that clears the low 'offs' address bits, giving a block-aligned address.
    function automatic logic [63:0] block_mask(input int offs);
        logic [63:0] m;
        m = '1;
        return m << offs;
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch / cache / IRAM signal bundle seen by the refill sequencer.
interface icache_refill_ctrl_if
    import icache_refill_ctrl_pkg::*;
#(
    parameter int PC_SIZE    = 32,
    parameter int BLOCK_BITS = 128
);
    logic [PC_SIZE-1:0]    fetch_pc;
    logic                  fetch_valid;
    logic                  flush;
    logic                  cache_hit;
    logic [PC_SIZE-1:0]    cache_pc;
    logic                  cache_we;
    logic [0:BLOCK_BITS-1] cache_block;
    logic                  stall;
    logic                  mem_req;
    logic [PC_SIZE-1:0]    mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [BEAT_BITS-1:0]  mem_rdata;
    logic                  mem_err;
    logic                  refill_err;
    logic [31:0]           miss_cnt;

    // Sequencer side.
    modport master (
        input  fetch_pc, fetch_valid, flush, cache_hit,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output cache_pc, cache_we, cache_block, stall,
        output mem_req, mem_addr, refill_err, miss_cnt
    );

    // Fetch unit, cache and IRAM side.
    modport slave (
        output fetch_pc, fetch_valid, flush, cache_hit,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  cache_pc, cache_we, cache_block, stall,
        input  mem_req, mem_addr, refill_err, miss_cnt
    );

endinterface

// File: rtl/icache_refill_ctrl_line_assembler.sv
// Collects IRAM beats into one cache block; beat 0 lands in block bits [0:31].
module line_assembler
    import icache_refill_ctrl_pkg::*;
#(
    parameter int BEATS = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         clr,
    input  logic                         load,
    input  logic [BEAT_BITS-1:0]         data,
    output logic                         last,
    output logic [0:BEATS*BEAT_BITS-1]   block
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0] beat_cnt;

    // Beat counter restarts at each grant; each loaded beat goes into its slot unchanged.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            beat_cnt <= '0;
            block    <= '0;
        end else begin
            if (clr)
                beat_cnt <= '0;
            else if (load)
                beat_cnt <= beat_cnt + 1'b1;
            for (int i = 0; i < BEATS; i++) begin
                if (load && beat_cnt == CNT_W'(i))
                    block[i*BEAT_BITS +: BEAT_BITS] <= data;
            end
        end
    end

    assign last = (beat_cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer: stalls fetch on a miss, fetches the line from IRAM,
// writes the assembled block into the cache and counts misses.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int PC_SIZE    = 32,
    parameter int BLOCK_BITS = 128
) (
    input  logic                  clk,
    input  logic                  nrst,
    icache_refill_ctrl_if.master  bus
);
    localparam int BEATS = BLOCK_BITS / BEAT_BITS;
    localparam int OFFS  = $clog2(BLOCK_BITS / 8);
    localparam logic [PC_SIZE-1:0] ALIGN_MASK = PC_SIZE'(block_mask(OFFS));

    refill_state_t         state, state_nxt;
    logic [PC_SIZE-1:0]    miss_addr;
    logic [31:0]           miss_cnt;
    logic                  miss_det;
    logic                  asm_clr, asm_load, asm_last;
    logic [0:BLOCK_BITS-1] asm_block;
    logic [PC_SIZE-1:0]    cache_pc;
    logic                  stall, mem_req, cache_we, refill_err;

    line_assembler #(.BEATS(BEATS)) u_line_assembler (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (asm_clr),
        .load  (asm_load),
        .data  (bus.mem_rdata),
        .last  (asm_last),
        .block (asm_block)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and outputs; miss detection is held off while reset is asserted.
    always_comb begin
        state_nxt  = state;
        cache_pc   = miss_addr;
        stall      = 1'b0;
        mem_req    = 1'b0;
        cache_we   = 1'b0;
        refill_err = 1'b0;
        miss_det   = 1'b0;
        asm_clr    = 1'b0;
        asm_load   = 1'b0;
        case (state)
            IDLE: begin
                cache_pc = bus.fetch_pc;
                miss_det = nrst & bus.fetch_valid & ~bus.cache_hit & ~bus.flush;
                stall    = miss_det;
                if (miss_det)
                    state_nxt = REQ;
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (bus.mem_gnt) begin
                    asm_clr   = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                stall = 1'b1;
                if (bus.mem_rvalid) begin
                    if (bus.mem_err) begin
                        refill_err = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        asm_load = 1'b1;
                        if (asm_last)
                            state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                stall     = 1'b1;
                cache_we  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the block-aligned miss address and count misses, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            miss_addr <= '0;
            miss_cnt  <= '0;
        end else if (miss_det) begin
            miss_addr <= bus.fetch_pc & ALIGN_MASK;
            if (miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign bus.cache_pc    = cache_pc;
    assign bus.cache_we    = cache_we;
    assign bus.cache_block = asm_block;
    assign bus.stall       = stall;
    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = miss_addr;
    assign bus.refill_err  = refill_err;
    assign bus.miss_cnt    = miss_cnt;

endmodule
